// File: rtl/gb_pkg.sv
// rtl/gb_pkg.sv - shared Game Boy memory-system constants and OAM DMA state type
package gb_pkg;

  localparam logic [15:0] OAM_DMA_REG_ADR = 16'hFF46;
  localparam int          OAM_SIZE        = 160;
  localparam logic [15:0] HRAM_FIRST      = 16'hFF80;
  localparam logic [15:0] HRAM_LAST       = 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE,
    START,
    XFER
  } oam_dma_state_t;

endpackage

// File: rtl/gb_oam_dma.sv
// rtl/gb_oam_dma.sv - OAM DMA controller: FF46 write copies {src,00}..{src,9F} into OAM
//
// Ports:
//   clk, n_reset          gbclk and asynchronous active-low reset
//   cpu_adr/cpu_dout/cpu_write   CPU bus; a write to FF46 starts (or restarts) a copy
//   reg_dout              FF46 readback (raw source page)
//   dma_adr/dma_read/dma_din     source read port towards the DMA-side decoder
//   oam_adr/oam_dout/oam_write   OAM write port, muxed in while active
//   active                transfer in progress
//   cpu_block             CPU access outside HRAM must be ignored (reads return FF)
//
// Build option: OAM_DMA_ECHO_FOLD_EN folds source pages E0..FF onto WRAM echo C0..DF.
module gb_oam_dma
  import gb_pkg::*;
#(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] cpu_adr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_write,
  output logic [7:0]  reg_dout,
  output logic [15:0] dma_adr,
  output logic        dma_read,
  input  logic [7:0]  dma_din,
  output logic [7:0]  oam_adr,
  output logic [7:0]  oam_dout,
  output logic        oam_write,
  output logic        active,
  output logic        cpu_block
);

  localparam logic [3:0] PH_LAST    = 4'(CYCLES_PER_BYTE - 1);
  localparam logic [3:0] PH_LATCH   = 4'(CYCLES_PER_BYTE - 2);
  localparam logic [3:0] DELAY_INIT = 4'(START_DELAY - 1);
  localparam logic [7:0] BYTE_LAST  = 8'(OAM_SIZE - 1);

  oam_dma_state_t state, state_nxt;
  logic [7:0] src;
  logic [7:0] src_eff;
  logic [7:0] data_q;
  logic [7:0] byte_cnt;
  logic [3:0] phase;
  logic [3:0] delay_cnt;
  logic       reg_hit;
  logic       in_hram;

  // The register hit is decoded independently of cpu_block, so FF46 writes
  // always land even while a transfer holds the bus.
  assign reg_hit  = cpu_write && (cpu_adr == OAM_DMA_REG_ADR);
  assign reg_dout = src;

`ifdef OAM_DMA_ECHO_FOLD_EN
  assign src_eff = (src >= 8'hE0) ? (src - 8'h20) : src;
`else
  assign src_eff = src;
`endif

  assign active    = (state != IDLE);
  assign in_hram   = (cpu_adr >= HRAM_FIRST) && (cpu_adr <= HRAM_LAST);
  assign cpu_block = active && !in_hram;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the bus strobes. The last phase of each byte is the write
  // phase; all earlier phases hold the source read.
  always_comb begin
    state_nxt = state;
    dma_read  = 1'b0;
    dma_adr   = 16'h0000;
    oam_write = 1'b0;
    oam_adr   = 8'h00;
    oam_dout  = 8'h00;
    case (state)
      IDLE: begin
        if (reg_hit) state_nxt = START;
      end
      START: begin
        if (reg_hit)               state_nxt = START;
        else if (delay_cnt == 4'd0) state_nxt = XFER;
      end
      XFER: begin
        if (phase != PH_LAST) begin
          dma_read = 1'b1;
          dma_adr  = {src_eff, byte_cnt};
        end else begin
          oam_write = 1'b1;
          oam_adr   = byte_cnt;
          oam_dout  = data_q;
          if (byte_cnt == BYTE_LAST) state_nxt = IDLE;
        end
        // A restart still lets the current write-phase strobe through.
        if (reg_hit) state_nxt = START;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      src       <= 8'hFF;
      data_q    <= 8'h00;
      byte_cnt  <= 8'h00;
      phase     <= 4'd0;
      delay_cnt <= 4'd0;
    end else begin
      if (reg_hit) begin
        src       <= cpu_dout;
        delay_cnt <= DELAY_INIT;
        phase     <= 4'd0;
        byte_cnt  <= 8'h00;
      end else begin
        case (state)
          START: begin
            if (delay_cnt != 4'd0) begin
              delay_cnt <= delay_cnt - 4'd1;
            end else begin
              phase    <= 4'd0;
              byte_cnt <= 8'h00;
            end
          end
          XFER: begin
            if (phase == PH_LATCH) data_q <= dma_din;
            if (phase == PH_LAST) begin
              phase <= 4'd0;
              // Wrap to 0 on the last byte so the index never exceeds 159.
              byte_cnt <= (byte_cnt == BYTE_LAST) ? 8'h00 : byte_cnt + 8'h01;
            end else begin
              phase <= phase + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gb_oam_dma.sv
// tb/tb_gb_oam_dma.sv - scoreboard testbench for gb_oam_dma
module tb_gb_oam_dma;

  typedef struct {
    logic [15:0] dadr;
    logic [7:0]  oadr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] cpu_adr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_write = 1'b0;
  logic [7:0]  reg_dout;
  logic [15:0] dma_adr;
  logic        dma_read;
  logic [7:0]  dma_din;
  logic [7:0]  oam_adr;
  logic [7:0]  oam_dout;
  logic        oam_write;
  logic        active;
  logic        cpu_block;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   wr_count = 0;
  int   cyc;

  always #5 clk = ~clk;

  // Source model: every address returns its low byte.
  assign dma_din = dma_adr[7:0];

  gb_oam_dma dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .cpu_adr   (cpu_adr),
    .cpu_dout  (cpu_dout),
    .cpu_write (cpu_write),
    .reg_dout  (reg_dout),
    .dma_adr   (dma_adr),
    .dma_read  (dma_read),
    .dma_din   (dma_din),
    .oam_adr   (oam_adr),
    .oam_dout  (oam_dout),
    .oam_write (oam_write),
    .active    (active),
    .cpu_block (cpu_block)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected event", name);
  endtask

  // Monitor: compare every source read and OAM write against the queue head.
  always @(negedge clk) begin
    if (n_reset) begin
      if (dma_read) begin
        if (exp_q.size() == 0) bad("unexpected_dma_read");
        else chk("dma_adr", dma_adr, exp_q[0].dadr);
      end
      if (oam_write) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          bad("unexpected_oam_write");
        end else begin
          chk("oam_adr", oam_adr, exp_q[0].oadr);
          chk("oam_dout", oam_dout, exp_q[0].data);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_xfer(input logic [7:0] page);
    exp_t e;
    for (int n = 0; n < 160; n++) begin
      e.dadr = {page, 8'(n)};
      e.oadr = 8'(n);
      e.data = 8'(n);
      exp_q.push_back(e);
    end
  endtask

  task automatic cpu_wr(input logic [15:0] adr, input logic [7:0] d);
    @(posedge clk);
    #1 cpu_adr = adr; cpu_dout = d; cpu_write = 1'b1;
    @(posedge clk);
    #1 cpu_write = 1'b0; cpu_adr = 16'h0000;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!active) return;
      n++;
    end
    bad("wait_idle");
  endtask

  task automatic wait_writes(input int target);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (wr_count >= target) return;
    end
    bad("wait_writes");
  endtask

  task automatic blk(input logic [15:0] adr, input logic exp, input string name);
    cpu_adr = adr;
    #1 chk(name, cpu_block, exp);
  endtask

  initial begin
    int strobes;
    logic [7:0] fold_page;

    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;
    #1;
    chk("reset_reg_dout", reg_dout, 8'hFF);
    chk("reset_active", active, 1'b0);
    chk("reset_dma_adr", dma_adr, 16'h0000);
    chk("reset_oam_write", oam_write, 1'b0);
    chk("reset_cpu_block", cpu_block, 1'b0);

    // Idle with no CPU writes: no strobes at all.
    strobes = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (dma_read || oam_write || active) strobes++;
    end
    chk("idle_strobes", strobes, 0);

    // Full transfer from page C1.
    wr_count = 0;
    push_xfer(8'hC1);
    cpu_wr(16'hFF46, 8'hC1);
    chk("reg_dout_c1", reg_dout, 8'hC1);
    fork
      wait_idle(cyc);
      begin
        repeat (20) @(posedge clk);
        #1;
        blk(16'hC000, 1'b1, "block_c000_active");
        blk(16'hFF80, 1'b0, "block_ff80_active");
        blk(16'hFFFF, 1'b1, "block_ffff_active");
        cpu_adr = 16'h0000;
      end
    join
    chk("active_cycles", cyc, 644);
    chk("write_count_c1", wr_count, 160);
    chk("queue_empty_c1", exp_q.size(), 0);
    @(posedge clk);
    #1;
    blk(16'hC000, 1'b0, "block_c000_idle");
    blk(16'hFF80, 1'b0, "block_ff80_idle");
    blk(16'hFFFF, 1'b0, "block_ffff_idle");
    cpu_adr = 16'h0000;

    // Restart at byte 50 with page D0.
    wr_count = 0;
    push_xfer(8'hC1);
    cpu_wr(16'hFF46, 8'hC1);
    wait_writes(50);
    cpu_wr(16'hFF46, 8'hD0);
    exp_q.delete();
    push_xfer(8'hD0);
    wait_idle(cyc);
    chk("restart_active_cycles", cyc, 644);
    chk("restart_write_count", wr_count, 210);
    chk("queue_empty_d0", exp_q.size(), 0);

    // Page E3, then reset mid-transfer at byte 80.
`ifdef OAM_DMA_ECHO_FOLD_EN
    fold_page = 8'hC3;
`else
    fold_page = 8'hE3;
`endif
    wr_count = 0;
    push_xfer(fold_page);
    cpu_wr(16'hFF46, 8'hE3);
    chk("reg_dout_e3", reg_dout, 8'hE3);
    wait_writes(80);
    @(posedge clk);
    #1 n_reset = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_active", active, 1'b0);
    chk("rst_dma_read", dma_read, 1'b0);
    chk("rst_dma_adr", dma_adr, 16'h0000);
    chk("rst_oam_write", oam_write, 1'b0);
    chk("rst_oam_adr", oam_adr, 8'h00);
    chk("rst_oam_dout", oam_dout, 8'h00);
    chk("rst_cpu_block", cpu_block, 1'b0);
    chk("rst_reg_dout", reg_dout, 8'hFF);
    repeat (5) @(posedge clk);
    #1 n_reset = 1'b1;
    strobes = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (oam_write || active) strobes++;
    end
    chk("post_reset_quiet", strobes, 0);
    chk("rst_write_count", wr_count, 80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
